wm_port_arbiter: RTL

Single-port weight-memory arbiter and address sequencer for the DTPU. It shares the weight memory between two requesters: the host-side loader writes weight bursts from the PS, and the compute control path reads a weight page for the MXU. It grants one burst at a time with round-robin priority and generates sequential addresses. For compute reads it converts a page index into a base address and returns read data with a fixed latency.

---
 rtl/wm_port_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wm_port_arbiter.sv
// wm_port_arbiter
// Purpose: shares one single-port weight memory between the host write-burst
//          loader and the compute read path. It grants one burst at a time
//          with round-robin priority and generates sequential addresses. For
//          compute it turns a page index into a base address and returns read
//          data one cycle after each memory read.
// Latency: grant pulse 1 cycle after the request is sampled in IDLE. Host
//          writes go out combinationally with each accepted beat. Compute
//          read data returns 1 cycle after its address.
// Backpressure: host beats are throttled only by host_wvalid_i (bubbles allowed),
//          and host_wready_o is high for the whole host burst. Compute reads run
//          one word per cycle and cannot be stalled.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   host_req_i/base_i/len_i host burst request, start address, length (words)
//   host_gnt_o, host_done_o one-cycle grant / burst-complete pulses
//   host_wvalid_i/wdata_i   write beats; host_wready_o accepts them
//   cu_req_i/page_i/len_i   compute read request, page index, length (words)
//   cu_gnt_o, cu_done_o     one-cycle grant pulse / pulse on the final read beat
//   cu_rvalid_o/rdata_o     returned read data
//   wm_ce_o/we_o/addr_o/din_o, wm_dout_i   weight-memory port
//   busy_o, owner_o         not idle / current owner (0 none, 1 host, 2 compute)

module wm_port_arbiter #(
  parameter int ADDRESS_SIZE_WMEMORY = 32,
  parameter int DATA_WIDTH_WMEMORY   = 64,
  parameter int PAGE_WORDS           = 9,
  parameter int LEN_W                = 8
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic                            host_req_i,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] host_base_i,
  input  logic [LEN_W-1:0]                host_len_i,
  output logic                            host_gnt_o,
  input  logic                            host_wvalid_i,
  input  logic [DATA_WIDTH_WMEMORY-1:0]   host_wdata_i,
  output logic                            host_wready_o,
  output logic                            host_done_o,

  input  logic                            cu_req_i,
  input  logic [ADDRESS_SIZE_WMEMORY-1:0] cu_page_i,
  input  logic [LEN_W-1:0]                cu_len_i,
  output logic                            cu_gnt_o,
  output logic                            cu_rvalid_o,
  output logic [DATA_WIDTH_WMEMORY-1:0]   cu_rdata_o,
  output logic                            cu_done_o,

  output logic                            wm_ce_o,
  output logic                            wm_we_o,
  output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_addr_o,
  output logic [DATA_WIDTH_WMEMORY-1:0]   wm_din_o,
  input  logic [DATA_WIDTH_WMEMORY-1:0]   wm_dout_i,

  output logic                            busy_o,
  output logic [1:0]                      owner_o
);

  localparam int AW = ADDRESS_SIZE_WMEMORY;
  localparam int DW = DATA_WIDTH_WMEMORY;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_HOST_BURST = 2'd1;
  localparam logic [1:0] ST_CU_BURST   = 2'd2;
  localparam logic [1:0] ST_CU_DRAIN   = 2'd3;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_HOST = 2'd1;
  localparam logic [1:0] OWNER_CU   = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  // High when compute received the most recent grant. It resets low (host),
  // so compute wins the first tie after reset.
  logic             last_cu_q, last_cu_d;
  logic             host_gnt_q, host_gnt_d;
  logic             cu_gnt_q, cu_gnt_d;
  logic             host_done_q, host_done_d;
  logic             cu_rvalid_q, cu_rvalid_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic          len_zero;
  logic          cnt_last;
  logic [AW-1:0] addr_cur;
  logic [AW-1:0] cu_base;
  logic          grant_cu;
  logic          grant_host;

  assign len_zero = (len_q == '0);
  // Only meaningful when len_q != 0, so the wrap of len_q-1 at zero is harmless.
  assign cnt_last = (cnt_q == (len_q - LEN_W'(1)));
  // Wraps modulo 2^AW by construction of the AW-bit sum.
  assign addr_cur = base_q + AW'(cnt_q);
  // Page index to word address, truncated to the address width.
  assign cu_base  = cu_page_i * AW'(PAGE_WORDS);

  // Round-robin: on a tie, the requester that was not granted last wins.
  assign grant_cu   = cu_req_i && (!host_req_i || !last_cu_q);
  assign grant_host = host_req_i && !grant_cu;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    last_cu_d   = last_cu_q;
    host_gnt_d  = 1'b0;
    cu_gnt_d    = 1'b0;
    host_done_d = 1'b0;
    cu_rvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Requests are only sampled here; a level still high on return to
        // IDLE counts as a fresh request.
        if (grant_cu) begin
          state_d   = ST_CU_BURST;
          base_d    = cu_base;
          len_d     = cu_len_i;
          cnt_d     = '0;
          cu_gnt_d  = 1'b1;
          last_cu_d = 1'b1;
        end else if (grant_host) begin
          state_d    = ST_HOST_BURST;
          base_d     = host_base_i;
          len_d      = host_len_i;
          cnt_d      = '0;
          host_gnt_d = 1'b1;
          last_cu_d  = 1'b0;
        end
      end

      ST_HOST_BURST: begin
        if (len_zero) begin
          // Empty burst: grant and done pulse together, no memory access.
          state_d = ST_IDLE;
        end else if (host_wvalid_i) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_last) begin
            // Leave immediately so wready drops in the done cycle.
            state_d     = ST_IDLE;
            cnt_d       = '0;
            host_done_d = 1'b1;
          end
        end
      end

      ST_CU_BURST: begin
        if (len_zero) begin
          // Empty read: no access, nothing to drain.
          state_d = ST_IDLE;
        end else begin
          cu_rvalid_d = 1'b1;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_last) begin
            state_d = ST_CU_DRAIN;
            cnt_d   = '0;
          end
        end
      end

      ST_CU_DRAIN: begin
        // One cycle to let the last read word come back.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      last_cu_q   <= 1'b0;
      host_gnt_q  <= 1'b0;
      cu_gnt_q    <= 1'b0;
      host_done_q <= 1'b0;
      cu_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      last_cu_q   <= last_cu_d;
      host_gnt_q  <= host_gnt_d;
      cu_gnt_q    <= cu_gnt_d;
      host_done_q <= host_done_d;
      cu_rvalid_q <= cu_rvalid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    wm_ce_o       = 1'b0;
    wm_we_o       = 1'b0;
    wm_addr_o     = '0;
    wm_din_o      = '0;
    host_wready_o = 1'b0;
    owner_o       = OWNER_NONE;

    case (state_q)
      ST_HOST_BURST: begin
        owner_o       = OWNER_HOST;
        host_wready_o = !len_zero;
        wm_ce_o       = host_wvalid_i && !len_zero;
        wm_we_o       = host_wvalid_i && !len_zero;
        wm_addr_o     = addr_cur;
        wm_din_o      = host_wdata_i;
      end
      ST_CU_BURST: begin
        owner_o   = OWNER_CU;
        wm_ce_o   = !len_zero;
        wm_addr_o = addr_cur;
      end
      ST_CU_DRAIN: begin
        owner_o = OWNER_CU;
      end
      default: begin
        owner_o = OWNER_NONE;
      end
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign host_gnt_o  = host_gnt_q;
  assign cu_gnt_o    = cu_gnt_q;
  assign host_done_o = host_done_q || ((state_q == ST_HOST_BURST) && len_zero);
  // The drain cycle carries the final read word.
  assign cu_done_o   = (state_q == ST_CU_DRAIN) || ((state_q == ST_CU_BURST) && len_zero);
  assign cu_rvalid_o = cu_rvalid_q;
  // Memory output passes through while valid; held at zero otherwise so the
  // port is quiet in reset and between reads.
  assign cu_rdata_o  = cu_rvalid_q ? wm_dout_i : {DW{1'b0}};

endmodule
